// File: rtl/uart_tx_arbiter.sv
// Purpose: shares one UARTTx between NUM_REQ requesters, granting whole messages round-robin.
// Latency: req to tx_en low is 1 cycle; a tx_complete rising edge to ack is 1 cycle.
// Backpressure: req is held until its ack; the owner keeps the lock and others wait until its last byte is acked.
module uart_tx_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_byte,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   ack,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy,
   output logic                 tx_en,
   output logic [7:0]           tx_byte,
   input  logic                 tx_complete
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      WAIT_DONE = 3'd2,
      ACK       = 3'd3,
      HOLD      = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic               last_q, last_d;
   logic               tc_q, tc_d;
   logic [NUM_REQ-1:0] grant_d, ack_d;
   logic               busy_d, tx_en_d;
   logic [7:0]         tx_byte_d;

   logic               pick_vld;
   logic [IDX_W-1:0]   pick_idx;
   logic [IDX_W-1:0]   cand;
   logic               load;
   logic [IDX_W-1:0]   load_idx;

   // Round-robin search: first requester at or above the pointer, wrapping at NUM_REQ-1.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
         if (!pick_vld && req[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   // State register plus all registered outputs and datapath state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         last_q  <= 1'b0;
         tc_q    <= 1'b1;
         grant   <= '0;
         ack     <= '0;
         busy    <= 1'b0;
         tx_en   <= 1'b1;
         tx_byte <= 8'h00;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         last_q  <= last_d;
         tc_q    <= tc_d;
         grant   <= grant_d;
         ack     <= ack_d;
         busy    <= busy_d;
         tx_en   <= tx_en_d;
         tx_byte <= tx_byte_d;
      end
   end

   // Next-state logic; completion is a rising edge of tx_complete against its history.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (pick_vld) state_d = START;
         START:     state_d = WAIT_DONE;
         WAIT_DONE: if (tx_complete && !tc_q) state_d = ACK;
         ACK:       state_d = last_q ? IDLE : HOLD;
         HOLD:      if (req[owner_q]) state_d = START;
         default:   state_d = IDLE;
      endcase
   end

   // Output/datapath next values, registered above so every output is a flop.
   always_comb begin
      load      = (state_q == IDLE && pick_vld) || (state_q == HOLD && req[owner_q]);
      load_idx  = (state_q == IDLE) ? pick_idx : owner_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      last_d    = last_q;
      tx_byte_d = tx_byte;
      grant_d   = grant;
      ack_d     = '0;
      if (load) begin
         owner_d           = load_idx;
         tx_byte_d         = req_byte[8*load_idx +: 8];
         last_d            = req_last[load_idx];
         grant_d           = '0;
         grant_d[load_idx] = 1'b1;
      end
      if (state_q == WAIT_DONE && state_d == ACK) begin
         ack_d[owner_q] = 1'b1;
      end
      // Pointer moves only when a whole message has finished.
      if (state_q == ACK && last_q) begin
         grant_d = '0;
         ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
      end
      tx_en_d = (state_d != START);
      busy_d  = (state_d != IDLE);
      // Entering START masks a completion level left high by the previous frame.
      tc_d    = (state_d == START) ? 1'b1 : tx_complete;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UARTTx transmitter between NUM_REQ independent requesters, e.g. the echo/"Ok" responder, a debug register dumper and a CPU console port.
- Grants whole messages (byte streams ending in a "last" byte) round-robin. The owner stays locked until its last byte has been transmitted, so messages never interleave on the wire.
- Sits between the requesters and UARTTx. It drives UARTTx's active-low tx_en strobe and tx_byte, and watches tx_complete.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); index 0 has highest priority out of reset.
- IDX_W, $clog2(NUM_REQ), width of the owner index and priority pointer (derived, not overridden).

Ports:
- clk  input  1  system clock (25 MHz board clock).
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester byte-valid; held high with data stable until the matching ack.
- req_byte  input  8*NUM_REQ  byte for requester i at [8i+7:8i].
- req_last  input  NUM_REQ  marks the current byte as the final byte of requester i's message.
- ack  output  NUM_REQ  one-cycle pulse: requester i's byte has finished transmitting.
- grant  output  NUM_REQ  one-hot current message owner; all zero when idle.
- busy  output  1  high whenever state is not IDLE.
- tx_en  output  1  to UARTTx; active-low one-cycle start strobe, idle high.
- tx_byte  output  8  to UARTTx; byte being sent, registered and stable from START until the next load.
- tx_complete  input  1  from UARTTx; a 0->1 transition marks end of frame.

Behaviour:
- Reset values (asynchronous):
  - state=IDLE, grant=0, ack=0, busy=0, tx_en=1, tx_byte=8'h00.
  - Priority pointer=0; last_q=0; tx_complete history register=1.
  - Reset mid-frame abandons the message with no ack. UARTTx is reset separately by its own reset.
- All outputs are registered. The FSM states are IDLE, START, WAIT_DONE, ACK and HOLD.
- IDLE:
  - If any req is high, pick the first requester with req=1 searching from pointer upward, wrapping modulo NUM_REQ.
  - Set grant one-hot, latch tx_byte=req_byte[owner] and last_q=req_last[owner], then go to START.
  - If no req is high, stay in IDLE.
- START: tx_en=0 for exactly this one cycle, then go to WAIT_DONE. tx_en returns to 1 on the next cycle.
- WAIT_DONE:
  - tx_complete is registered each cycle into tc_q. Completion is tx_complete=1 && tc_q=0.
  - tc_q is forced to 1 on entry to START, so a level already high from the previous frame is never taken as completion.
  - On completion, go to ACK. There is no timeout.
- ACK:
  - ack[owner]=1 for this one cycle.
  - If last_q=1: grant=0, pointer=(owner+1) mod NUM_REQ, go to IDLE.
  - Otherwise go to HOLD with grant unchanged.
- HOLD:
  - Owner keeps the lock; other requesters are ignored.
  - When req[owner]=1, latch tx_byte and last_q from the owner and go to START. Otherwise wait indefinitely.
- Requester rule: update req_byte/req_last, or drop req, on the clock edge that ends the ack cycle.
  - After acking a last byte the requester must drop req or present a new message. A still-high req in IDLE is treated as a new message.
- Latency:
  - req seen in IDLE at cycle k -> tx_en low at cycle k+1.
  - tx_complete edge sampled at cycle m -> ack at cycle m+1.
  - HOLD with req high at cycle k -> tx_en low at cycle k+1.
- Simultaneous requests are resolved by the rotating pointer only. Pointer advances only on message end, never per byte.
- Requests that drop before being granted are simply never served; no state is kept per requester.
- Out-of-range bits never exist because grant is one-hot over NUM_REQ. For non-power-of-2 NUM_REQ the pointer wraps at NUM_REQ-1 -> 0.

Test Plan:
- Single byte: req[1]=1, byte 8'h4F, last=1 -> tx_en low exactly 1 cycle with tx_byte=8'h4F; ack[1] one cycle after tx_complete rises; grant returns to 0; pointer=2.
- 4-byte message: requester 0 sends "O","k",8'h0D,8'h0A with last on the 4th byte while req[2] is held high throughout -> four frames in order, grant[0] held throughout, grant[2] issued only after the 4th ack.
- Round-robin: req=4'b1111 continuously, single-byte messages -> grant order 0,1,2,3,0; no requester served twice before all others are served.
- Stale completion: tx_complete held at 1 between frames -> no ack until tx_complete goes 0 then 1 after the new START; exactly one ack per frame.
- Owner stall in HOLD: requester 3 drops req for 50 cycles mid-message while req[0]=1 -> tx_en stays high, grant stays 4'b1000, and the message resumes when req[3] returns.
- Reset mid-frame: assert reset during WAIT_DONE -> outputs immediately at reset values; after release, req[2] is granted before req[3] according to pointer=0 order; no ack for the aborted byte.
